storage_bist_wbm: RTL and testbench

STORAGE_BIST_WBM -- requirements
Module: storage_bist_wbm

---
 rtl/storage_bist_wbm.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_storage_bist_wbm.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/storage_bist_wbm.sv
// storage_bist_wbm -- Wishbone master memory BIST.
//
// A run writes word_count words of a Galois LFSR pattern to consecutive
// word addresses starting at BASE_ADR. It then reloads the seed and reads
// the same words back. Each read is compared against the regenerated
// pattern. The run stops at the first mismatch, which is recorded in
// fail_adr/fail_data.
//
// Optional feature: define STORAGE_BIST_TIMEOUT_EN to compile in a
// per-transfer watchdog. A transfer with no ack for TIMEOUT cycles aborts
// the run with timeout=1. Without the macro the master waits forever for
// ack, and timeout is tied low.
//
// Ports
//   wb_clk_i, wb_rst_i       clock, asynchronous active-low reset
//   start                    single-cycle request to begin a run (ignored while busy)
//   word_count[8:0], seed    run parameters, sampled on an accepted start
//   busy, done               run in progress / one-cycle end-of-run pulse
//   pass, timeout            result of the last run
//   fail_adr, fail_data      address and data of the first mismatch (data 0 on timeout)
//   wbm_*                    Wishbone classic master port
module storage_bist_wbm #(
  parameter logic [31:0] BASE_ADR = 32'h0100_0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [8:0]  word_count,
  input  logic [31:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] fail_adr,
  output logic [31:0] fail_data,
  output logic        timeout,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        tmo_q, tmo_d;
  logic [31:0] fail_adr_q, fail_adr_d;
  logic [31:0] fail_data_q, fail_data_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] seed_q, seed_d;
  logic [8:0]  idx_q, idx_d;
  logic [8:0]  cnt_q, cnt_d;

  logic [31:0] seed_eff;
  logic        ack_ok;
  logic        in_req;

  // One right-shift Galois step. The output bit feeds back into the tap
  // positions.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  // Byte address of word k. The add wraps modulo 2^32.
  function automatic logic [31:0] word_adr(input logic [8:0] k);
    return BASE_ADR + {21'd0, k, 2'b00};
  endfunction

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  assign seed_eff = (seed == 32'h0000_0000) ? 32'h0000_0001 : seed;

  // Acks are only meaningful while this master owns the bus.
  assign ack_ok = wbm_ack_i & cyc_q;
  assign in_req = (state_q == WR_REQ) || (state_q == RD_REQ);

`ifdef STORAGE_BIST_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;
  logic        wdog_expired;

  // The counter counts request cycles without an ack. It returns to zero
  // outside the request states, so every transfer starts from zero.
  always_comb begin
    wdog_d = '0;
    if (in_req && !ack_ok) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  // This is the TIMEOUT-th request cycle with no ack.
  assign wdog_expired = (wdog_q >= (32'(TIMEOUT) - 32'd1));
`else
  logic        wdog_expired;
  logic [31:0] unused_timeout;

  assign wdog_expired   = 1'b0;
  // TIMEOUT only matters when the watchdog is compiled in.
  assign unused_timeout = 32'(TIMEOUT);
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    tmo_d       = tmo_q;
    fail_adr_d  = fail_adr_q;
    fail_data_d = fail_data_q;
    lfsr_d      = lfsr_q;
    seed_d      = seed_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          tmo_d       = 1'b0;
          fail_adr_d  = '0;
          fail_data_d = '0;
          seed_d      = seed_eff;
          lfsr_d      = seed_eff;
          cnt_d       = word_count;
          idx_d       = '0;
          if (word_count == 9'd0) begin
            // An empty run passes trivially and never touches the bus.
            pass_d  = 1'b1;
            state_d = FIN;
          end else begin
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            sel_d   = 4'hF;
            adr_d   = BASE_ADR;
            dat_d   = seed_eff;
            state_d = WR_REQ;
          end
        end
      end

      WR_REQ: begin
        if (ack_ok) begin
          cyc_d   = 1'b0;
          lfsr_d  = lfsr_step(lfsr_q);
          idx_d   = idx_q + 9'd1;
          state_d = WR_GAP;
        end
      end

      WR_GAP: begin
        cyc_d = 1'b1;
        sel_d = 4'hF;
        if (idx_q == cnt_q) begin
          // All words are written. Restart the pattern for the read pass.
          lfsr_d  = seed_q;
          idx_d   = '0;
          we_d    = 1'b0;
          adr_d   = BASE_ADR;
          state_d = RD_REQ;
        end else begin
          adr_d   = word_adr(idx_q);
          dat_d   = lfsr_q;
          state_d = WR_REQ;
        end
      end

      RD_REQ: begin
        if (ack_ok) begin
          cyc_d = 1'b0;
          if (wbm_dat_i != lfsr_q) begin
            fail_adr_d  = adr_q;
            fail_data_d = wbm_dat_i;
            pass_d      = 1'b0;
            state_d     = FIN;
          end else if ((idx_q + 9'd1) == cnt_q) begin
            pass_d  = 1'b1;
            state_d = FIN;
          end else begin
            lfsr_d  = lfsr_step(lfsr_q);
            idx_d   = idx_q + 9'd1;
            state_d = RD_GAP;
          end
        end
      end

      RD_GAP: begin
        cyc_d   = 1'b1;
        adr_d   = word_adr(idx_q);
        state_d = RD_REQ;
      end

      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A watchdog abort overrides whatever the request state chose above.
    if (in_req && !ack_ok && wdog_expired) begin
      cyc_d       = 1'b0;
      tmo_d       = 1'b1;
      pass_d      = 1'b0;
      fail_adr_d  = adr_q;
      fail_data_d = '0;
      state_d     = FIN;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      tmo_q       <= 1'b0;
      fail_adr_q  <= '0;
      fail_data_q <= '0;
      lfsr_q      <= '0;
      seed_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      tmo_q       <= tmo_d;
      fail_adr_q  <= fail_adr_d;
      fail_data_q <= fail_data_d;
      lfsr_q      <= lfsr_d;
      seed_q      <= seed_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
    end
  end

  // Classic single transfers: strobe always equals cycle.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = tmo_q;
  assign fail_adr  = fail_adr_q;
  assign fail_data = fail_data_q;

endmodule

// File: tb/tb_storage_bist_wbm.sv
// Testbench for storage_bist_wbm. A storage responder has programmable ack
// latency and can corrupt one word's read data. Expected results come from
// the LFSR definition and the run rules.
module tb_storage_bist_wbm;

  localparam logic [31:0] BASE = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  wc = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, tmo;
  logic [31:0] fail_adr, fail_data;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdat = '0;

  int vectors = 0;
  int miscompares = 0;

  storage_bist_wbm #(.BASE_ADR(BASE), .TIMEOUT(255)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst_n), .start(start), .word_count(wc), .seed(seed),
    .busy(busy), .done(done), .pass(pass), .fail_adr(fail_adr), .fail_data(fail_data),
    .timeout(tmo), .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
    .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_ack_i(ack), .wbm_dat_i(rdat)
  );

  always #5 clk = ~clk;

  // Storage responder
  logic [31:0] mem [0:255];
  int          lat = 0;
  bit          ack_en = 1'b1;
  bit          spur_ack = 1'b0;
  int          corrupt_idx = -1;
  logic [31:0] corrupt_mask = '0;
  int          wait_cnt = 0;
  logic        ack_r = 1'b0;
  logic [7:0]  widx;

  assign widx = 8'((adr - BASE) >> 2);
  assign ack  = ack_r | spur_ack;

  always @(posedge clk) begin
    if (ack_r || !(cyc && stb)) begin
      ack_r    <= 1'b0;
      wait_cnt <= 0;
    end else if (ack_en) begin
      if (wait_cnt >= lat) begin
        ack_r <= 1'b1;
        if (we) mem[widx] <= dat_o;
        else    rdat <= mem[widx] ^ ((int'(widx) == corrupt_idx) ? corrupt_mask : 32'h0);
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end
  end

  // Bus monitor
  bit          mon_clr = 1'b0;
  int          n_wr = 0, n_rd = 0, n_xfer = 0, done_cnt = 0, stb_cycles = 0, unstable = 0;
  bit          cyc_seen = 1'b0;
  longint      cyc_no = 0;
  longint      xfer_cyc [0:1];
  logic [31:0] wr_adr [0:511];
  logic [31:0] wr_dat [0:511];
  logic        prev_stb = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_adr = '0, prev_dat = '0;

  always @(posedge clk) begin
    if (mon_clr) begin
      n_wr <= 0; n_rd <= 0; n_xfer <= 0; done_cnt <= 0;
      stb_cycles <= 0; unstable <= 0; cyc_seen <= 1'b0;
    end else begin
      if (cyc)  cyc_seen <= 1'b1;
      if (stb)  stb_cycles <= stb_cycles + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (stb && prev_stb && (adr != prev_adr || dat_o != prev_dat || we != prev_we))
        unstable <= unstable + 1;
      if (cyc && stb && ack) begin
        if (we) begin
          if (n_wr < 512) begin
            wr_adr[n_wr] <= adr;
            wr_dat[n_wr] <= dat_o;
          end
          n_wr <= n_wr + 1;
        end else begin
          n_rd <= n_rd + 1;
        end
        if (n_xfer < 2) xfer_cyc[n_xfer] <= cyc_no;
        n_xfer <= n_xfer + 1;
      end
    end
    prev_stb <= stb; prev_we <= we; prev_adr <= adr; prev_dat <= dat_o;
    cyc_no   <= cyc_no + 1;
  end

  // Reference model: word k of a run is the seed advanced k times.
  function automatic logic [31:0] pat_at(input logic [31:0] s, input int k);
    logic [31:0] p;
    p = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < k; i++) p = p[0] ? ((p >> 1) ^ 32'h8020_0003) : (p >> 1);
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(negedge clk); mon_clr = 1'b0;
  endtask

  task automatic launch(input logic [8:0] w, input logic [31:0] s,
                        input int ci, input logic [31:0] cm, input int l);
    lat = l; corrupt_idx = ci; corrupt_mask = cm;
    clear_mon();
    @(negedge clk); wc = w; seed = s; start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic verify(input string nm, input logic [8:0] w, input logic [31:0] s,
                        input int ci, input logic [31:0] cm, input int l);
    bit ok;
    bit exp_pass;
    int exp_rd;
    wait_done(ok);
    check({nm, ".done_seen"}, 32'(ok), 32'd1);
    exp_pass = !(ci >= 0 && ci < int'(w) && cm != 32'h0);
    exp_rd   = exp_pass ? int'(w) : ci + 1;
    check({nm, ".pass"}, 32'(pass), 32'(exp_pass));
    check({nm, ".busy"}, 32'(busy), 32'd0);
    check({nm, ".timeout"}, 32'(tmo), 32'd0);
    check({nm, ".writes"}, 32'(n_wr), 32'(w));
    check({nm, ".reads"}, 32'(n_rd), 32'(exp_rd));
    check({nm, ".stable"}, 32'(unstable), 32'd0);
    check({nm, ".period"}, 32'(xfer_cyc[1] - xfer_cyc[0]), 32'(l + 3));
    if (!exp_pass) begin
      check({nm, ".fail_adr"}, fail_adr, BASE + 32'(ci * 4));
      check({nm, ".fail_data"}, fail_data, pat_at(s, ci) ^ cm);
    end
    for (int k = 0; k < int'(w); k++) begin
      check($sformatf("%s.wadr%0d", nm, k), wr_adr[k], BASE + 32'(k * 4));
      check($sformatf("%s.wdat%0d", nm, k), wr_dat[k], pat_at(s, k));
    end
    @(posedge clk); #1;
    check({nm, ".done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          found;
    logic [8:0]  rw;
    logic [31:0] rs;
    int          rl, rc;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.pass", 32'(pass), 32'd0);
    check("rst.cyc", 32'({cyc, stb, we}), 32'd0);
    check("rst.adr", adr, 32'd0);
    check("rst.dat", dat_o, 32'd0);
    check("rst.sel", 32'(sel), 32'd0);
    check("rst.fail", fail_adr | fail_data, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Acks while the bus is idle must not start anything
    clear_mon();
    @(negedge clk); spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    check("spur.busy", 32'(busy), 32'd0);
    check("spur.cyc_seen", 32'(cyc_seen), 32'd0);
    check("spur.done_cnt", 32'(done_cnt), 32'd0);

    // Full run. A second start arrives while busy and must be ignored.
    launch(9'd100, 32'h1234_5678, -1, 32'h0, 1);
    repeat (20) @(negedge clk);
    wc = 9'd3; seed = 32'hDEAD_BEEF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    verify("full", 9'd100, 32'h1234_5678, -1, 32'h0, 1);

    // Read of word 7 comes back with bit 0 flipped
    launch(9'd100, 32'h1234_5678, 7, 32'h1, 0);
    verify("corrupt7", 9'd100, 32'h1234_5678, 7, 32'h1, 0);
    check("corrupt7.adr_const", fail_adr, 32'h0100_001C);

    // Zero-length run: done one cycle after FIN, no bus activity
    clear_mon();
    @(negedge clk); wc = 9'd0; seed = 32'h5; start = 1'b1;
    @(posedge clk); #1;
    check("wc0.busy", 32'(busy), 32'd1);
    check("wc0.done_early", 32'(done), 32'd0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("wc0.done", 32'(done), 32'd1);
    check("wc0.pass", 32'(pass), 32'd1);
    check("wc0.busy_after", 32'(busy), 32'd0);
    check("wc0.cyc_seen", 32'(cyc_seen), 32'd0);

    // A zero seed runs as seed 1
    launch(9'd2, 32'h0, -1, 32'h0, 2);
    verify("seed0", 9'd2, 32'h0, -1, 32'h0, 2);
    check("seed0.w0", wr_dat[0], 32'h0000_0001);
    check("seed0.w1", wr_dat[1], 32'h8020_0003);
    check("seed0.a1", wr_adr[1], 32'h0100_0004);

    // Reset while the third write has its strobe up
    launch(9'd10, 32'hCAFE_0001, -1, 32'h0, 1);
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (n_wr == 2 && stb) begin found = 1'b1; break; end
    end
    check("rstmid.reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid.cyc", 32'({cyc, stb}), 32'd0);
    check("rstmid.busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rstmid.no_done", 32'(done_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    launch(9'd5, 32'h0BAD_F00D, -1, 32'h0, 0);
    verify("after_rst", 9'd5, 32'h0BAD_F00D, -1, 32'h0, 0);

    // Randomised runs
    rw = 9'($urandom_range(1, 64)); rs = $urandom; rl = int'($urandom_range(0, 3));
    launch(rw, rs, -1, 32'h0, rl);
    verify("rnd_pass", rw, rs, -1, 32'h0, rl);

    rw = 9'($urandom_range(2, 64)); rs = $urandom; rl = int'($urandom_range(0, 3));
    rc = int'($urandom_range(0, 32'(rw) - 1));
    launch(rw, rs, rc, 32'h1 << $urandom_range(0, 31), rl);
    verify("rnd_fail", rw, rs, rc, corrupt_mask, rl);

    rs = $urandom; rl = int'($urandom_range(0, 3));
    launch(9'd256, rs, -1, 32'h0, rl);
    verify("max256", 9'd256, rs, -1, 32'h0, rl);

`ifdef STORAGE_BIST_TIMEOUT_EN
    // The responder never acks, so the watchdog must abort the run
    ack_en = 1'b0;
    launch(9'd3, 32'h1234_5678, -1, 32'h0, 0);
    wait_done(found);
    check("tmo.done_seen", 32'(found), 32'd1);
    check("tmo.timeout", 32'(tmo), 32'd1);
    check("tmo.pass", 32'(pass), 32'd0);
    check("tmo.fail_adr", fail_adr, 32'h0100_0000);
    check("tmo.fail_data", fail_data, 32'h0);
    check("tmo.stb_cycles", 32'(stb_cycles), 32'd255);
    check("tmo.cyc", 32'(cyc), 32'd0);
    ack_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
